// File: rtl/if_stage_pc_unit_if.sv
// if_stage_pc_unit_if: signal bundle between decode/hazard logic and the fetch PC unit
// master: decode/hazard side, drives stall, branch_taken/target, jump/jump_index and the imem read data instr
// slave : the fetch unit, drives pc, pc_plus4, pc_sel, the IF/ID register outputs and addr_error
interface if_stage_pc_unit_if #(parameter int N = 32);
  logic stall, branch_taken, jump, ifid_valid, addr_error;
  logic [N-1:0] branch_target, instr, pc, pc_plus4, ifid_pc, ifid_pc_plus4, ifid_instr;
  logic [25:0] jump_index;
  logic [1:0] pc_sel;
  modport master (
    output stall, branch_taken, branch_target, jump, jump_index, instr,
    input pc, pc_plus4, pc_sel, ifid_pc, ifid_pc_plus4, ifid_instr, ifid_valid, addr_error
  );
  modport slave (
    input stall, branch_taken, branch_target, jump, jump_index, instr,
    output pc, pc_plus4, pc_sel, ifid_pc, ifid_pc_plus4, ifid_instr, ifid_valid, addr_error
  );
endinterface

// File: rtl/if_stage_pc_unit.sv
// if_stage_pc_unit: MIPS fetch stage owning the PC and the IF/ID pipeline register
// clk, reset (async, active-high); bus (slave): redirect/stall controls and instr in,
// pc/pc_plus4/pc_sel and the registered IF/ID fields plus sticky addr_error out
module if_stage_pc_unit #(
  parameter int N = 32,
  parameter logic [N-1:0] RESET_VECTOR = '0
) (
  input logic clk,
  input logic reset,
  if_stage_pc_unit_if.slave bus
);
  logic [N-1:0] jump_target, next_pc;
  logic bad_branch;
  assign bus.pc_plus4 = bus.pc + N'(4);
  // jump region comes from the jump instruction's own PC+4, which sits in IF/ID
  assign jump_target = {bus.ifid_pc_plus4[N-1:N-4], bus.jump_index, 2'b00};
  assign bus.pc_sel = bus.jump ? 2'd2 : bus.branch_taken ? 2'd1 : 2'd0;
  assign next_pc = bus.jump ? jump_target : bus.branch_target;
  assign bad_branch = bus.branch_taken & ~bus.jump & (|bus.branch_target[1:0]);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.pc <= RESET_VECTOR;
      bus.ifid_pc <= '0;
      bus.ifid_pc_plus4 <= '0;
      bus.ifid_instr <= '0;
      bus.ifid_valid <= 1'b0;
      bus.addr_error <= 1'b0;
    end else if (!bus.addr_error) begin
      if (bad_branch) begin
        bus.addr_error <= 1'b1;
        bus.ifid_valid <= 1'b0;
      end else if (bus.jump || bus.branch_taken) begin
        bus.pc <= next_pc;
        bus.ifid_pc <= '0;
        bus.ifid_pc_plus4 <= '0;
        bus.ifid_instr <= '0;
        bus.ifid_valid <= 1'b0;
      end else if (!bus.stall) begin
        bus.pc <= bus.pc_plus4;
        bus.ifid_pc <= bus.pc;
        bus.ifid_pc_plus4 <= bus.pc_plus4;
        bus.ifid_instr <= bus.instr;
        bus.ifid_valid <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_if_stage_pc_unit.sv
// tb_if_stage_pc_unit: directed and randomized checks of the fetch PC unit against a rule-level model
module tb_if_stage_pc_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int passed = 0;
  int err_cycles = 0;
  logic [31:0] m_pc, m_ifid_pc, m_ifid_pc4, m_ifid_instr;
  logic m_valid, m_err;
  logic [31:0] jt_exp;
  if_stage_pc_unit_if #(.N(32)) bus ();
  if_stage_pc_unit #(.N(32), .RESET_VECTOR(32'h0)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask
  task automatic model_reset();
    m_pc = 32'h0;
    m_ifid_pc = 32'h0;
    m_ifid_pc4 = 32'h0;
    m_ifid_instr = 32'h0;
    m_valid = 1'b0;
    m_err = 1'b0;
  endtask
  task automatic model_edge();
    logic [31:0] jt;
    jt = {m_ifid_pc4[31:28], bus.jump_index, 2'b00};
    if (m_err) return;
    if (bus.branch_taken && !bus.jump && bus.branch_target[1:0] != 2'b00) begin
      m_err = 1'b1;
      m_valid = 1'b0;
    end else if (bus.jump || bus.branch_taken) begin
      m_pc = bus.jump ? jt : bus.branch_target;
      m_ifid_pc = 32'h0;
      m_ifid_pc4 = 32'h0;
      m_ifid_instr = 32'h0;
      m_valid = 1'b0;
    end else if (!bus.stall) begin
      m_ifid_pc = m_pc;
      m_ifid_pc4 = m_pc + 32'd4;
      m_ifid_instr = bus.instr;
      m_valid = 1'b1;
      m_pc = m_pc + 32'd4;
    end
  endtask
  task automatic check_all(string tag);
    chk({tag, ".pc"}, bus.pc, m_pc);
    chk({tag, ".pc_plus4"}, bus.pc_plus4, m_pc + 32'd4);
    chk({tag, ".pc_sel"}, 32'(bus.pc_sel), bus.jump ? 32'd2 : bus.branch_taken ? 32'd1 : 32'd0);
    chk({tag, ".ifid_pc"}, bus.ifid_pc, m_ifid_pc);
    chk({tag, ".ifid_pc4"}, bus.ifid_pc_plus4, m_ifid_pc4);
    chk({tag, ".ifid_instr"}, bus.ifid_instr, m_ifid_instr);
    chk({tag, ".ifid_valid"}, 32'(bus.ifid_valid), 32'(m_valid));
    chk({tag, ".addr_error"}, 32'(bus.addr_error), 32'(m_err));
  endtask
  task automatic cyc(string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all(tag);
  endtask
  task automatic drive(logic st, logic br, logic [31:0] tgt, logic jp, logic [25:0] ji);
    bus.stall = st;
    bus.branch_taken = br;
    bus.branch_target = tgt;
    bus.jump = jp;
    bus.jump_index = ji;
    bus.instr = $urandom;
  endtask
  task automatic do_reset(string tag);
    reset = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    #1;
    reset = 1'b0;
  endtask
  initial begin
    drive(0, 0, 0, 0, 0);
    model_reset();
    #3;
    check_all("reset");
    @(negedge clk);
    reset = 1'b0;
    chk("t1.pc_after_reset", bus.pc, 32'h0);
    for (int i = 1; i <= 4; i++) begin
      drive(0, 0, 0, 0, 0);
      cyc("t1");
      chk("t1.pc_seq", bus.pc, 32'(4 * i));
      chk("t1.ifid_pc_trails", bus.ifid_pc, 32'(4 * (i - 1)));
      chk("t1.valid", 32'(bus.ifid_valid), 32'd1);
    end
    drive(0, 1, 32'h0040_0020, 0, 0);
    cyc("t2_setup_br");
    drive(0, 0, 0, 0, 0);
    cyc("t2_setup_run");
    chk("t2.ifid_pc4", bus.ifid_pc_plus4, 32'h0040_0024);
    drive(0, 0, 0, 1, 26'h010_0010);
    #1;
    chk("t2.pc_sel", 32'(bus.pc_sel), 32'd2);
    cyc("t2_jump");
    chk("t2.pc_target", bus.pc, 32'h0040_0040);
    chk("t2.bubble", 32'(bus.ifid_valid), 32'd0);
    drive(0, 0, 0, 0, 0);
    cyc("t2_after");
    chk("t2.valid_again", 32'(bus.ifid_valid), 32'd1);
    drive(0, 1, 32'h100, 0, 0);
    cyc("t3_setup");
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0, 0);
      cyc("t3_stall");
      chk("t3.pc_held", bus.pc, 32'h100);
    end
    drive(0, 0, 0, 0, 0);
    cyc("t3_resume");
    chk("t3.pc_resumed", bus.pc, 32'h104);
    drive(0, 1, 32'h0FFF_FFFC, 0, 0);
    cyc("t4_setup_br");
    drive(0, 0, 0, 0, 0);
    cyc("t4_setup_run");
    chk("t4.ifid_pc4", bus.ifid_pc_plus4, 32'h1000_0000);
    drive(1, 1, 32'h200, 1, 26'h2AB_CDEF);
    #1;
    chk("t4.pc_sel", 32'(bus.pc_sel), 32'd2);
    cyc("t4_jump");
    jt_exp = {4'h1, 26'h2AB_CDEF, 2'b00};
    chk("t4.pc_jump_wins", bus.pc, jt_exp);
    chk("t4.bubble", 32'(bus.ifid_valid), 32'd0);
    drive(0, 1, 32'h202, 0, 0);
    cyc("t5_bad");
    chk("t5.addr_error", 32'(bus.addr_error), 32'd1);
    for (int i = 0; i < 4; i++) begin
      drive(i[0], i[1], 32'h300, i[0], 26'h155);
      cyc("t5_frozen");
      chk("t5.pc_frozen", bus.pc, jt_exp);
    end
    do_reset("t5_reset");
    chk("t5.pc_reset", bus.pc, 32'h0);
    drive(0, 1, 32'hFFFF_FFFC, 0, 0);
    cyc("t6_setup");
    drive(0, 0, 0, 0, 0);
    cyc("t6_wrap");
    chk("t6.pc_wrap", bus.pc, 32'h0);
    chk("t6.no_error", 32'(bus.addr_error), 32'd0);
    cyc("t6_run");
    #2;
    do_reset("t6_async");
    chk("t6.async_valid", 32'(bus.ifid_valid), 32'd0);
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
            ($urandom_range(0, 19) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC),
            $urandom_range(0, 7) == 0, 26'($urandom));
      cyc("rand");
      if (m_err && ++err_cycles > 3) begin
        err_cycles = 0;
        do_reset("rand_reset");
      end
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
